// File: rtl/xor_nor_comparator_if.sv
// Operand/result bundle for the ID-stage equality comparator.
// The ID stage drives the operands (master); the comparator returns the flags (slave).
interface xor_nor_comparator_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   reg_read_data_1;
    logic [WIDTH-1:0]   reg_read_data_2;
    logic               cmp_en;
    logic [WIDTH-1:0]   xor_result;
    logic               nor_result;
    logic               ne_result;
    logic [WIDTH/8-1:0] byte_eq;
    logic               a_zero;
    logic               a_neg;
    logic               eq_q;
    logic               eq_valid_q;

    modport master (
        output reg_read_data_1,
        output reg_read_data_2,
        output cmp_en,
        input  xor_result,
        input  nor_result,
        input  ne_result,
        input  byte_eq,
        input  a_zero,
        input  a_neg,
        input  eq_q,
        input  eq_valid_q
    );

    modport slave (
        input  reg_read_data_1,
        input  reg_read_data_2,
        input  cmp_en,
        output xor_result,
        output nor_result,
        output ne_result,
        output byte_eq,
        output a_zero,
        output a_neg,
        output eq_q,
        output eq_valid_q
    );
endinterface

// File: rtl/xor_nor_comparator.sv
// XOR/NOR equality comparator for early branch resolution in ID,
// with byte-equality mask, operand-A sign/zero flags and a registered result.
module xor_nor_comparator #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xor_nor_comparator_if.slave   bus
);
    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0]  w_xor;
    logic              w_eq;
    logic [NBYTES-1:0] w_byte_eq;
    logic              r_eq;
    logic              r_eq_valid;

    assign w_xor = bus.reg_read_data_1 ^ bus.reg_read_data_2;
    assign w_eq  = ~|w_xor;

    for (genvar g = 0; g < NBYTES; g++) begin : g_byte
        assign w_byte_eq[g] = ~|w_xor[8*g +: 8];
    end

    // Register stage only captures on cmp_en; the flags stay purely combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq       <= 1'b0;
            r_eq_valid <= 1'b0;
        end else begin
            r_eq_valid <= bus.cmp_en;
            if (bus.cmp_en) begin
                r_eq <= w_eq;
            end
        end
    end

    assign bus.xor_result = w_xor;
    assign bus.nor_result = w_eq;
    assign bus.ne_result  = ~w_eq;
    assign bus.byte_eq    = w_byte_eq;
    assign bus.a_zero     = ~|bus.reg_read_data_1;
    assign bus.a_neg      = bus.reg_read_data_1[WIDTH-1];
    assign bus.eq_q       = r_eq;
    assign bus.eq_valid_q = r_eq_valid;
endmodule

// File: tb/tb_xor_nor_comparator.sv
// Scoreboard bench for xor_nor_comparator: combinational flags and
// the registered eq_q/eq_valid_q path including asynchronous reset.
module tb_xor_nor_comparator;
    typedef struct packed {
        logic [31:0] xr;
        logic        nr;
        logic        ne;
        logic [3:0]  be;
        logic        az;
        logic        an;
    } comb_t;

    typedef struct packed {
        logic eq;
        logic v;
    } reg_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    comb_t comb_q[$];
    reg_t  reg_q[$];

    xor_nor_comparator_if #(.WIDTH(32)) bus ();

    xor_nor_comparator #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got running, need finished");
        $fatal(1);
    end

    function automatic comb_t model(input logic [31:0] a, input logic [31:0] b);
        comb_t m;
        m.xr = a ^ b;
        m.nr = (a == b);
        m.ne = (a != b);
        for (int i = 0; i < 4; i++) begin
            m.be[i] = (a[8*i +: 8] == b[8*i +: 8]);
        end
        m.az = (a == 32'd0);
        m.an = a[31];
        return m;
    endfunction

    function automatic comb_t obs_comb();
        comb_t o;
        o.xr = bus.xor_result;
        o.nr = bus.nor_result;
        o.ne = bus.ne_result;
        o.be = bus.byte_eq;
        o.az = bus.a_zero;
        o.an = bus.a_neg;
        return o;
    endfunction

    task automatic test_directed();
        logic [31:0] av[7];
        logic [31:0] bv[7];
        comb_t       got;
        comb_t       exp;
        av = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5A3C_B2F1,
               32'h1234_5678, 32'h1234_5678, 32'h8000_0000};
        bv = '{32'h0000_0000, 32'h0000_0000, 32'hAAAA_AAAA, 32'hA5C3_4D0E,
               32'h1234_5679, 32'h12FF_5678, 32'h8000_0000};
        comb_q.push_back('{32'h0000_0000, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0});
        comb_q.push_back('{32'hFFFF_FFFF, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1});
        comb_q.push_back('{32'h0000_0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1});
        comb_q.push_back('{32'hFFFF_FFFF, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0});
        comb_q.push_back('{32'h0000_0001, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0});
        comb_q.push_back('{32'h00CB_0000, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0});
        comb_q.push_back('{32'h0000_0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1});
        for (int i = 0; i < 7; i++) begin
            bus.reg_read_data_1 = av[i];
            bus.reg_read_data_2 = bv[i];
            #1;
            got = obs_comb();
            exp = comb_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL directed[%0d] a=%h b=%h: got %h, need %h",
                         i, av[i], bv[i], got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        comb_t       got;
        comb_t       exp;
        for (int i = 0; i < 32; i++) begin
            a = $urandom;
            b = a;
            case (i % 4)
                0: b = $urandom;
                1: b = a ^ (32'h1 << $urandom_range(31, 0));
                2: b[8*(i%4) +: 8] = ~a[8*(i%4) +: 8];
                default: ;
            endcase
            comb_q.push_back(model(a, b));
            bus.reg_read_data_1 = a;
            bus.reg_read_data_2 = b;
            #1;
            got = obs_comb();
            exp = comb_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h: got %h, need %h",
                         i, a, b, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        reg_t got;
        reg_t exp;
        @(negedge clk);
        rst_n = 1'b0;
        bus.cmp_en = 1'b1;
        bus.reg_read_data_1 = 32'h1;
        bus.reg_read_data_2 = 32'h1;
        reg_q.push_back('{1'b0, 1'b0});
        @(posedge clk);
        #1;
        got = '{bus.eq_q, bus.eq_valid_q};
        exp = reg_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_hold: got eq_q/valid=%b, need %b", got, exp);
        end
    endtask

    task automatic test_capture_hold();
        reg_t got;
        reg_t exp;
        @(negedge clk);
        rst_n = 1'b1;
        bus.cmp_en = 1'b1;
        bus.reg_read_data_1 = 32'hCAFE_F00D;
        bus.reg_read_data_2 = 32'hCAFE_F00D;
        reg_q.push_back('{1'b1, 1'b1});
        @(posedge clk);
        #1;
        got = '{bus.eq_q, bus.eq_valid_q};
        exp = reg_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL capture: got eq_q/valid=%b, need %b", got, exp);
        end
        @(negedge clk);
        bus.cmp_en = 1'b0;
        bus.reg_read_data_2 = 32'h0BAD_F00D;
        reg_q.push_back('{1'b1, 1'b0});
        @(posedge clk);
        #1;
        got = '{bus.eq_q, bus.eq_valid_q};
        exp = reg_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL hold: got eq_q/valid=%b, need %b", got, exp);
        end
    endtask

    task automatic test_async_reset();
        reg_t got;
        reg_t exp;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        reg_q.push_back('{1'b0, 1'b0});
        #1;
        got = '{bus.eq_q, bus.eq_valid_q};
        exp = reg_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL async_reset: got eq_q/valid=%b, need %b", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        reg_t        got;
        reg_t        exp;
        logic        held;
        logic [31:0] a;
        logic [31:0] b;
        logic        en;
        held = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a  = $urandom;
            b  = (i % 3 == 0) ? a : ((i % 3 == 1) ? a ^ 32'h8000_0000 : $urandom);
            en = (i % 5 != 4);
            bus.reg_read_data_1 = a;
            bus.reg_read_data_2 = b;
            bus.cmp_en = en;
            if (en) held = (a == b);
            reg_q.push_back('{held, en});
            @(posedge clk);
            #1;
            got = '{bus.eq_q, bus.eq_valid_q};
            exp = reg_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL b2b[%0d] a=%h b=%h en=%b: got %b, need %b",
                         i, a, b, en, got, exp);
            end
        end
        // Reset and capture on the same edge: reset must win.
        @(negedge clk);
        rst_n = 1'b0;
        bus.cmp_en = 1'b1;
        bus.reg_read_data_2 = bus.reg_read_data_1;
        reg_q.push_back('{1'b0, 1'b0});
        @(posedge clk);
        #1;
        got = '{bus.eq_q, bus.eq_valid_q};
        exp = reg_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_wins: got %b, need %b", got, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.cmp_en = 1'b0;
        bus.reg_read_data_1 = '0;
        bus.reg_read_data_2 = '0;
        test_directed();
        test_random();
        test_reset();
        test_capture_hold();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
